// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - shared types, size codes and store formatting for the LSU
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // True when the access size is illegal or the address is not naturally aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            SIZE_W:  bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Returns {be, wdata}: store data replicated across lanes with the matching byte enables.
    function automatic logic [35:0] store_format(input logic [1:0] size, input logic [1:0] offset,
                                                 input logic [31:0] data);
        logic [3:0]  be;
        logic [31:0] wd;
        case (size)
            SIZE_B: begin
                wd = {4{data[7:0]}};
                be = 4'b0001 << offset;
            end
            SIZE_H: begin
                wd = {2{data[15:0]}};
                be = 4'b0011 << offset;
            end
            SIZE_W: begin
                wd = data;
                be = 4'b1111;
            end
            default: begin
                wd = data;
                be = 4'b0000;
            end
        endcase
        return {be, wd};
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data-memory request/response bus between LSU and memory
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, we, addr, wdata, be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, we, addr, wdata, be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_stage_lsu_load_formatter.sv
// rtl/mem_stage_lsu_load_formatter.sv - lane select and sign/zero extension of load data
module mem_load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);
    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend according to size and signedness.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SIZE_B:  result = is_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  result = is_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with pipeline stall control
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_valid,
    input  logic              op_load,
    input  logic              op_store,
    input  logic [1:0]        op_size,
    input  logic              op_unsigned,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    mem_stage_lsu_if.master   dmem,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              done,
    output logic              misaligned,
    output logic              bus_err
);
    lsu_state_t state_q, state_d;

    logic              access;
    logic              op_bad;
    logic              stall_c;
    logic              req_valid_c;
    logic              done_c;
    logic              latch_c;
    logic              capture_c;

    logic [ADDR_W-3:0] addr_word_q;
    logic [1:0]        offset_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       load_data_q;
    logic              bus_err_q;
    logic [31:0]       fmt_result;

    assign access = op_valid & (op_load | op_store);
    assign op_bad = is_misaligned(op_size, op_addr[1:0]);

    // The op inputs only matter in IDLE; in DONE the same instruction is still present.
    assign misaligned = access & op_bad & (state_q == IDLE);

    // State register; asynchronous reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and control decode.
    always_comb begin
        state_d     = state_q;
        stall_c     = 1'b0;
        req_valid_c = 1'b0;
        done_c      = 1'b0;
        latch_c     = 1'b0;
        capture_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !op_bad) begin
                    stall_c = 1'b1;
                    latch_c = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall_c     = 1'b1;
                req_valid_c = 1'b1;
                if (dmem.req_ready) state_d = RSP;
            end
            RSP: begin
                stall_c = 1'b1;
                if (dmem.rsp_valid) begin
                    capture_c = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The IDLE detect path is combinational on the op inputs, so mask it while reset is held.
    assign stall          = stall_c & reset_n;
    assign done           = done_c;
    assign dmem.req_valid = req_valid_c;

    // Capture the request when the access is accepted in IDLE; fields stay frozen until reuse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_word_q <= '0;
            offset_q    <= 2'b00;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
        end else if (latch_c) begin
            addr_word_q <= op_addr[ADDR_W-1:2];
            offset_q    <= op_addr[1:0];
            size_q      <= op_size;
            unsigned_q  <= op_unsigned;
            we_q        <= op_store;
            {be_q, wdata_q} <= store_format(op_size, op_addr[1:0], op_wdata);
            if (!op_store) be_q <= 4'h0;
        end
    end

    assign dmem.addr  = {addr_word_q, 2'b00};
    assign dmem.we    = we_q;
    assign dmem.wdata = wdata_q;
    assign dmem.be    = be_q;

    mem_load_formatter u_fmt (
        .rdata       (dmem.rsp_rdata),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (fmt_result)
    );

    // Register the completion result; stores leave the previous load value untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_data_q <= 32'h0;
            bus_err_q   <= 1'b0;
        end else if (capture_c) begin
            bus_err_q <= dmem.rsp_err;
            if (!we_q) load_data_q <= fmt_result;
        end
    end

    assign load_data = load_data_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;
    logic        clk;
    logic        reset_n;
    logic        op_valid;
    logic        op_load;
    logic        op_store;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        misaligned;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] load_data;
        logic        bus_err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_load;

    mem_stage_lsu_if #(.ADDR_W(32)) dmem ();

    mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_valid    (op_valid),
        .op_load     (op_load),
        .op_store    (op_store),
        .op_size     (op_size),
        .op_unsigned (op_unsigned),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .dmem        (dmem),
        .stall       (stall),
        .load_data   (load_data),
        .done        (done),
        .misaligned  (misaligned),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_ops();
        op_valid    = 1'b0;
        op_load     = 1'b0;
        op_store    = 1'b0;
        op_size     = 2'b00;
        op_unsigned = 1'b0;
        op_addr     = 32'h0;
        op_wdata    = 32'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_ops();
        dmem.req_ready = 1'b0;
        dmem.rsp_valid = 1'b0;
        dmem.rsp_rdata = 32'h0;
        dmem.rsp_err   = 1'b0;
        last_load      = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, done, dmem.req_valid, bus_err, misaligned} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {stall, done, dmem.req_valid, bus_err, misaligned});
        end
        checks++;
        if (load_data !== 32'h0 || dmem.be !== 4'h0 || dmem.addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: load_data=%h be=%b addr=%h required 0", load_data, dmem.be, dmem.addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One access with a responsive memory model; the expected completion goes on the scoreboard.
    task automatic run_access(input string name, input logic st, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input int rdy_wait, input int rsp_wait,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_be, input logic [31:0] exp_load);
        exp_t e;
        exp_t got;
        int   stall_cnt = 0;
        int   rw = 0;
        int   sw = 0;
        int   done_cyc = -1;
        bit   accepted = 0;
        bit   got_done = 0;
        bit   req_bad = 0;

        @(posedge clk);
        #1;
        op_valid    = 1'b1;
        op_load     = ~st;
        op_store    = st;
        op_size     = sz;
        op_unsigned = uns;
        op_addr     = addr;
        op_wdata    = wdata;
        if (!st) last_load = exp_load;
        e.load_data = last_load;
        e.bus_err   = err;
        sb.push_back(e);

        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            dmem.rsp_valid = 1'b0;
            if (dmem.req_valid) begin
                if (dmem.addr !== exp_addr || dmem.be !== (st ? exp_be : 4'h0) || dmem.we !== st ||
                    (st && dmem.wdata !== exp_wdata)) req_bad = 1;
                if (rw == rdy_wait) begin
                    dmem.req_ready = 1'b1;
                    accepted       = 1;
                end else begin
                    dmem.req_ready = 1'b0;
                    rw++;
                end
            end else begin
                dmem.req_ready = 1'b0;
                if (accepted && stall) begin
                    if (sw == rsp_wait) begin
                        dmem.rsp_valid = 1'b1;
                        dmem.rsp_rdata = rdata;
                        dmem.rsp_err   = err;
                    end else begin
                        sw++;
                    end
                end
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                clear_ops();
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s_sb: done with empty scoreboard", name);
                end else begin
                    got = sb.pop_front();
                    if (load_data !== got.load_data || bus_err !== got.bus_err) begin
                        errors++;
                        $display("FAIL %s_result: load_data=%h bus_err=%b required %h %b",
                                 name, load_data, bus_err, got.load_data, got.bus_err);
                    end
                end
            end
        end

        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s_timeout: no done within 40 cycles", name);
            sb.delete();
            clear_ops();
        end
        checks++;
        if (!accepted || req_bad) begin
            errors++;
            $display("FAIL %s_request: accepted=%0d fields_bad=%0d required 1 0", name, accepted, req_bad);
        end
        checks++;
        if (stall_cnt != 3 + rdy_wait + rsp_wait || done_cyc != 3 + rdy_wait + rsp_wait) begin
            errors++;
            $display("FAIL %s_timing: stall=%0d done_cycle=%0d required %0d %0d",
                     name, stall_cnt, done_cyc, 3 + rdy_wait + rsp_wait, 3 + rdy_wait + rsp_wait);
        end
        // Result must hold after DONE until the next completion.
        @(negedge clk);
        checks++;
        if (load_data !== last_load || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: load_data=%h done=%b stall=%b required %h 0 0",
                     name, load_data, done, stall, last_load);
        end
    endtask

    task automatic test_word_load();
        run_access("word_load", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0,
                   32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
    endtask

    task automatic test_byte_load();
        run_access("byte_signed", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFF7F, 1'b0, 0, 0,
                   32'h100, 32'h0, 4'h0, 32'hFFFFFF80);
        run_access("byte_unsigned", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFF7F, 1'b0, 0, 0,
                   32'h100, 32'h0, 4'h0, 32'h00000080);
    endtask

    task automatic test_half_store();
        run_access("half_store", 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 1'b0, 2, 0,
                   32'h200, 32'hABCDABCD, 4'b1100, 32'h0);
    endtask

    task automatic test_misaligned();
        logic [1:0]  sizes [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] addrs [3] = '{32'h101, 32'h100, 32'h103};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            op_valid = 1'b1;
            op_load  = 1'b1;
            op_size  = sizes[i];
            op_addr  = addrs[i];
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checks++;
                if (misaligned !== 1'b1 || stall !== 1'b0 || dmem.req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL misaligned_%0d: mis=%b stall=%b req_valid=%b required 1 0 0",
                             i, misaligned, stall, dmem.req_valid);
                end
            end
            clear_ops();
        end
        // A non-memory op with a misaligned-looking address is not an access.
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op_size  = 2'b10;
        op_addr  = 32'h101;
        @(negedge clk);
        checks++;
        if (misaligned !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL non_mem_op: mis=%b stall=%b required 0 0", misaligned, stall);
        end
        clear_ops();
    endtask

    task automatic test_bus_err();
        run_access("bus_err", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0BADF00D, 1'b1, 0, 1,
                   32'h400, 32'h0, 4'h0, 32'h0BADF00D);
    endtask

    task automatic test_back_to_back();
        run_access("half_signed", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80017FFF, 1'b0, 1, 1,
                   32'h100, 32'h0, 4'h0, 32'hFFFF8001);
        run_access("byte_store", 1'b1, 2'b00, 1'b0, 32'h001, 32'h00000055, 32'h0, 1'b0, 0, 2,
                   32'h000, 32'h55555555, 4'b0010, 32'h0);
        run_access("word_store", 1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0, 1'b1, 0, 0,
                   32'h300, 32'hCAFEF00D, 4'b1111, 32'h0);
    endtask

    // Abort an access with reset while in REQ (in_rsp=0) or RSP (in_rsp=1).
    task automatic test_reset_mid(input bit in_rsp);
        bit saw_done = 0;
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op_load  = 1'b1;
        op_size  = 2'b10;
        op_addr  = 32'h500;
        @(negedge clk);
        @(negedge clk);
        if (in_rsp) begin
            dmem.req_ready = 1'b1;
            @(negedge clk);
            dmem.req_ready = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || dmem.req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_%0d: stall=%b req_valid=%b required 0 0", in_rsp, stall, dmem.req_valid);
        end
        clear_ops();
        @(negedge clk);
        reset_n   = 1'b1;
        last_load = 32'h0;
        dmem.rsp_valid = 1'b1;
        dmem.rsp_rdata = 32'h12345678;
        dmem.rsp_err   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dmem.rsp_valid = 1'b0;
            if (done || stall) saw_done = 1;
        end
        checks++;
        if (saw_done || load_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_late_rsp_%0d: done_or_stall=%0d load_data=%h required 0 0",
                     in_rsp, saw_done, load_data);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_bus_err();
        test_back_to_back();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_word_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
